// File: rtl/dm_pkg.sv
// Shared constants, FSM encodings and the byte-merge helper for the data-memory responder.
package dm_pkg;

    localparam int unsigned DM_CNT_W       = 4;
    localparam int unsigned DM_DEPTH_WORDS = 3072;

    typedef logic [1:0] dm_state_t;

    localparam dm_state_t ST_IDLE = 2'd0;
    localparam dm_state_t ST_WAIT = 2'd1;
    localparam dm_state_t ST_RESP = 2'd2;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word storage with async clear, byte-enabled write port and registered read data.
// Optional macro DM_DISPLAY_EN logs every committed store.
module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    input  logic [31:0]   pc_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[idx_i] <= dm_merge(mem_q[idx_i], wdata_i, be_i);
        end
    end

    // Read register is zeroed for stores and out-of-range accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

`ifdef DM_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_i) begin
            $display("@%08h: *%08h <= %08h", pc_i, 32'({idx_i, 2'b00}),
                     dm_merge(mem_q[idx_i], wdata_i, be_i));
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: valid/ready request and response channels with wait states.
// Optional macro DM_DISPLAY_EN (handled in dm_array) logs in-range stores.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_LIM = DEPTH_WORDS * 4;

    dm_state_t             state_q, state_d;
    logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;

    logic                  accept_c;
    logic                  in_range_c;

    assign accept_c   = (state_q == ST_IDLE) && req_valid;
    assign in_range_c = req_addr < 32'(BYTE_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    cnt_d   = (WAIT_CYCLES > 0) ? DM_CNT_W'(WAIT_CYCLES - 1) : '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - DM_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            if (accept_c) resp_err_q <= ~in_range_c;
        end
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk      (clk),
        .rst_n    (reset),
        .wr_en_i  (accept_c && req_we && in_range_c),
        .be_i     (req_be),
        .idx_i    (req_addr[AW+1:2]),
        .wdata_i  (req_wdata),
        .pc_i     (req_pc),
        .rd_en_i  (accept_c && !req_we && in_range_c),
        .rd_clr_i (accept_c && (req_we || !in_range_c)),
        .rdata_o  (resp_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder with default parameters (WAIT_CYCLES=2).
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response with resp_ready held high; latency counted in cycles after acceptance.
    task automatic xact(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_be     = be;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_be     = 4'h0;
        req_addr   = '0;
        req_wdata  = '0;
        req_pc     = 32'h0000_3004;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b1;

        xact("st_full", 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("ld_full", 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact("st_byte1", 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500, 32'h0, 1'b0);
        xact("ld_byte1", 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 1'b0);
        xact("st_be0", 1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xact("ld_be0", 1'b0, 4'h0, 32'h0000_0013, 32'h0, 32'hDEAD_55EF, 1'b0);
        xact("ld_oor", 1'b0, 4'h0, 32'h0000_3000, 32'h0, 32'h0, 1'b1);
        xact("st_oor", 1'b1, 4'hF, 32'h0000_3000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xact("ld_after_oor0", 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
        xact("ld_after_oor10", 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_55EF, 1'b0);
        xact("st_top", 1'b1, 4'hF, 32'h0000_2FFC, 32'hA5A5_0F0F, 32'h0, 1'b0);
        xact("ld_top", 1'b0, 4'h0, 32'h0000_2FFC, 32'h0, 32'hA5A5_0F0F, 1'b0);
        xact("st_log", 1'b1, 4'hF, 32'h0000_0014, 32'h1234_5678, 32'h0, 1'b0);
        xact("ld_log", 1'b0, 4'h0, 32'h0000_0014, 32'h0, 32'h1234_5678, 1'b0);

        // Backpressure in RESP with a competing request that must not be accepted.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_be     = 4'h0;
        req_addr   = 32'h0000_0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check("bp_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_be    = 4'hF;
            req_addr  = 32'h0000_0020;
            req_wdata = 32'h1111_1111;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_rdata", resp_rdata, 32'hDEAD_55EF);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        xact("ld_not_taken", 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset while a load is waiting.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        xact("ld_after_rst", 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);
        xact("ld_after_rst_top", 1'b0, 4'h0, 32'h0000_2FFC, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core: it serves word-addressed load/store requests issued by the memory stage over a valid/ready request channel and returns results over a valid/ready response channel. It applies byte-enable stores, inserts a configurable number of wait states, and flags out-of-range accesses. It sits behind the memory stage and replaces the single-cycle data memory when multi-cycle memory timing is modelled.

## Interface
Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words (byte range 0x0000 to 0x2FFF)
- WAIT_CYCLES, 2, wait states between acceptance and response (0 to 15)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_be  input  4  byte enables; bit i covers data bits [8i+7:8i]
- req_addr  input  32  byte address; bits [1:0] ignored
- req_wdata  input  32  store data, already lane-aligned
- req_pc  input  32  PC of the issuing instruction (logging only)
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts the response
- resp_rdata  output  32  load data (full word)
- resp_err  output  1  access was out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1, the request is accepted at that edge.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - The wait counter loads WAIT_CYCLES-1.
- WAIT: req_ready=0. The counter decrements each cycle. When it reaches 0, the next state is RESP.
- RESP: resp_valid=1. When resp_ready=1, the next state is IDLE.
  - Response outputs hold stable while resp_ready=0.
- Acceptance-edge actions:
  - Store: for each byte with be[i]=1, mem[addr[13:2]] byte i <= wdata byte i. Other bytes are unchanged. be=4'b0000 is a no-op store that still completes.
  - Load: resp_rdata is registered as mem[addr[13:2]], sampled before any other change.
  - Store: resp_rdata is registered as 0.
- Out of range is req_addr >= DEPTH_WORDS*4. For such an access:
  - resp_err=1 and resp_rdata=0.
  - The memory array is not modified.
  - The access otherwise follows normal timing.
- Only one request is outstanding at a time. The responder never drops or reorders requests.
- The requester must hold the request fields stable while req_valid=1 and req_ready=0.

## Timing
- Reset values, applied asynchronously on reset=0:
  - State is IDLE, so req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter is 0.
  - All memory words are 0.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
  - WAIT_CYCLES=0 gives 1 cycle.
  - WAIT_CYCLES=2 gives 3 cycles.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. IDLE is always re-entered for one cycle before the next acceptance.
- req_valid high in WAIT or RESP is not accepted; the request waits for IDLE.
- Reset during WAIT or RESP:
  - The pending response is discarded and the FSM returns to IDLE.
  - A store issued before reset was already committed, but memory is then cleared by the reset.
- A load to the address just stored by the previous request returns the new data.

## Configuration
- DM_DISPLAY_EN defined: on every in-range store acceptance, print `@<req_pc>: *<word-aligned addr> <= <merged word>` (hex, 8 digits) using $display. Timing is unaffected.
- DM_DISPLAY_EN undefined: no simulation output. Logic is identical and req_pc is unused.

## Structure
- Package dm_pkg holds:
  - the FSM state enum (IDLE/WAIT/RESP)
  - the wait-counter width constant (4)
  - the default DEPTH_WORDS constant
  - the byte-merge function
- One sub-module, dm_array, is natural. It holds the storage: async clear, byte-enabled write port, synchronous read register.
- dm_responder keeps the FSM, counter, range check and response registers.

## Test plan
- Reset, then store addr=0x0000_0010, be=4'hF, wdata=0xDEAD_BEEF, then load 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after each acceptance (WAIT_CYCLES=2).
- Store be=4'b0010, wdata=0x0000_5500 to 0x10 after the above → load returns 0xDEAD55EF.
- Load addr=0x0000_3000 → resp_err=1, resp_rdata=0. A store to 0x3000 leaves every word unchanged.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stay stable, req_ready=0, a concurrent req_valid is not accepted.
- Assert reset=0 mid-WAIT → resp_valid=0 and req_ready=1 immediately (no clock needed), and a load of 0x10 afterwards returns 0.
- With DM_DISPLAY_EN and req_pc=0x0000_3004, store 0x1234_5678 to 0x14 → log line `@00003004: *00000014 <= 12345678`.
